// File: rtl/gnr_pkg.sv
// rtl/gnr_pkg.sv - shared widths and saturating counter helper for GRN blocks
package gnr_pkg;

    localparam int STATE_W_DEF = 1;
    localparam int CNT_W_DEF   = 16;

    // Increment holding at the all-ones value of a counter `width` bits wide (1..32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - width);
        return (val == max_v) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/gnr_node_tracker_if.sv
// rtl/gnr_node_tracker_if.sv - step strobes, candidate next states and tracked node state
interface gnr_node_tracker_if
    import gnr_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
);

    logic               start_s0;
    logic               start_s1;
    logic [STATE_W-1:0] next_s0;
    logic [STATE_W-1:0] next_s1;
    logic [STATE_W-1:0] s0;
    logic [STATE_W-1:0] s1;
    logic [STATE_W-1:0] node_s0;
    logic [STATE_W-1:0] node_s1;
    logic               match;

    modport master (
        output start_s0, start_s1, next_s0, next_s1,
        input  s0, s1, node_s0, node_s1, match
    );

    modport slave (
        input  start_s0, start_s1, next_s0, next_s1,
        output s0, s1, node_s0, node_s1, match
    );

endinterface

// File: rtl/gnr_step_div.sv
// rtl/gnr_step_div.sv - slow-copy phase counter, fires on every SLOW_DIV-th strobe
module gnr_step_div #(
    parameter int SLOW_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic reset_nos_i,
    input  logic start_i,
    output logic fire_o
);

    localparam int PH_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    assign fire_o = start_i && !rst && !reset_nos_i && (phase_q == '0);

    always_comb begin
        phase_d = phase_q;
        if (reset_nos_i) begin
            phase_d = '0;
        end else if (start_i) begin
            phase_d = (phase_q == '0) ? PH_LAST : phase_q - 1'b1;
        end
    end

    // After a hard reset the slow copy waits SLOW_DIV-1 strobes before its first step.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_LAST;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/gnr_node_tracker.sv
// rtl/gnr_node_tracker.sv - tortoise/hare node state tracker with sticky attractor detector
module gnr_node_tracker
    import gnr_pkg::*;
#(
    parameter int STATE_W  = STATE_W_DEF,
    parameter int SLOW_DIV = 2,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_nos,
    input  logic [STATE_W-1:0] init_state,
    gnr_node_tracker_if.slave  trk,
    output logic [CNT_W-1:0]   s0_steps,
    output logic [CNT_W-1:0]   s1_steps,
    output logic               cycle_found,
    output logic [CNT_W-1:0]   cycle_step
);

    logic [STATE_W-1:0] s0_q, s0_d;
    logic [STATE_W-1:0] s1_q, s1_d;
    logic [CNT_W-1:0]   s0_steps_q, s0_steps_d;
    logic [CNT_W-1:0]   s1_steps_q, s1_steps_d;
    logic               found_q, found_d;
    logic [CNT_W-1:0]   cstep_q, cstep_d;
    logic               s0_fire;
    logic               detect;

    gnr_step_div #(
        .SLOW_DIV (SLOW_DIV)
    ) u_step_div (
        .clk         (clk),
        .rst         (rst),
        .reset_nos_i (reset_nos),
        .start_i     (trk.start_s0),
        .fire_o      (s0_fire)
    );

    // Detection looks at the registered trajectories, so it lags the meeting by one cycle.
    assign detect = (s0_q == s1_q) && (s1_steps_q != '0) && !found_q;

    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        s0_steps_d = s0_steps_q;
        s1_steps_d = s1_steps_q;
        found_d    = found_q;
        cstep_d    = cstep_q;
        if (reset_nos) begin
            s0_d       = init_state;
            s1_d       = init_state;
            s0_steps_d = '0;
            s1_steps_d = '0;
            found_d    = 1'b0;
            cstep_d    = '0;
        end else begin
            if (s0_fire) begin
                s0_d       = trk.next_s0;
                s0_steps_d = CNT_W'(sat_inc(32'(s0_steps_q), CNT_W));
            end
            if (trk.start_s1) begin
                s1_d       = trk.next_s1;
                s1_steps_d = CNT_W'(sat_inc(32'(s1_steps_q), CNT_W));
            end
            if (detect) begin
                found_d = 1'b1;
                cstep_d = s1_steps_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            s0_steps_q <= '0;
            s1_steps_q <= '0;
            found_q    <= 1'b0;
            cstep_q    <= '0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s0_steps_q <= s0_steps_d;
            s1_steps_q <= s1_steps_d;
            found_q    <= found_d;
            cstep_q    <= cstep_d;
        end
    end

    assign trk.s0      = s0_q;
    assign trk.s1      = s1_q;
    assign trk.node_s0 = s0_q;
    assign trk.node_s1 = s1_q;
    assign trk.match   = (s0_q == s1_q);
    assign s0_steps    = s0_steps_q;
    assign s1_steps    = s1_steps_q;
    assign cycle_found = found_q;
    assign cycle_step  = cstep_q;

endmodule

// File: tb/tb_gnr_node_tracker.sv
// tb/tb_gnr_node_tracker.sv - directed and randomized checks of gnr_node_tracker against a reference model
module tb_gnr_node_tracker;

    logic       clk;
    logic       rst;
    logic       reset_nos;
    logic [3:0] init_a;
    logic       init_b;

    logic [2:0] a_s0_steps, a_s1_steps, a_cstep;
    logic       a_found;
    logic [7:0] b_s0_steps, b_s1_steps, b_cstep;
    logic       b_found;

    int checks = 0;
    int errors = 0;

    gnr_node_tracker_if #(.STATE_W(4)) ifa ();
    gnr_node_tracker_if #(.STATE_W(1)) ifb ();

    gnr_node_tracker #(.STATE_W(4), .SLOW_DIV(2), .CNT_W(3)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .reset_nos   (reset_nos),
        .init_state  (init_a),
        .trk         (ifa.slave),
        .s0_steps    (a_s0_steps),
        .s1_steps    (a_s1_steps),
        .cycle_found (a_found),
        .cycle_step  (a_cstep)
    );

    gnr_node_tracker #(.STATE_W(1), .SLOW_DIV(3), .CNT_W(8)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .reset_nos   (reset_nos),
        .init_state  (init_b),
        .trk         (ifb.slave),
        .s0_steps    (b_s0_steps),
        .s1_steps    (b_s1_steps),
        .cycle_found (b_found),
        .cycle_step  (b_cstep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned s0, s1, st0, st1, cstep, ph_cnt, ph_off;
        bit          found;
    } mdl_t;

    mdl_t ma, mb;
    int unsigned tbl_a[16];
    int unsigned tbl_b[2];

    // Slow copy: counting strobes since the last reset, it steps whenever the count
    // modulo div equals the offset (div-1 after rst, 0 after a run restart).
    function automatic mdl_t mdl_step(mdl_t m, bit r, bit rn, int unsigned ini, bit a, bit b,
                                      int unsigned n0, int unsigned n1, int unsigned div,
                                      int unsigned cmax);
        mdl_t x = m;
        if (r) begin
            x.s0 = 0; x.s1 = 0; x.st0 = 0; x.st1 = 0;
            x.found = 0; x.cstep = 0; x.ph_cnt = 0; x.ph_off = div - 1;
        end else if (rn) begin
            x.s0 = ini; x.s1 = ini; x.st0 = 0; x.st1 = 0;
            x.found = 0; x.cstep = 0; x.ph_cnt = 0; x.ph_off = 0;
        end else begin
            if (!m.found && m.s0 == m.s1 && m.st1 != 0) begin
                x.found = 1;
                x.cstep = m.st1;
            end
            if (a) begin
                if (m.ph_cnt == m.ph_off) begin
                    x.s0 = n0;
                    if (m.st0 < cmax) x.st0 = m.st0 + 1;
                end
                x.ph_cnt = (m.ph_cnt + 1) % div;
            end
            if (b) begin
                x.s1 = n1;
                if (m.st1 < cmax) x.st1 = m.st1 + 1;
            end
        end
        return x;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("a_s0",      32'(ifa.s0),      ma.s0);
        check_eq("a_s1",      32'(ifa.s1),      ma.s1);
        check_eq("a_node_s0", 32'(ifa.node_s0), ma.s0);
        check_eq("a_node_s1", 32'(ifa.node_s1), ma.s1);
        check_eq("a_match",   32'(ifa.match),   32'(ma.s0 == ma.s1));
        check_eq("a_s0_steps", 32'(a_s0_steps), ma.st0);
        check_eq("a_s1_steps", 32'(a_s1_steps), ma.st1);
        check_eq("a_found",   32'(a_found),     32'(ma.found));
        check_eq("a_cstep",   32'(a_cstep),     ma.cstep);
        check_eq("b_s0",      32'(ifb.s0),      mb.s0);
        check_eq("b_s1",      32'(ifb.s1),      mb.s1);
        check_eq("b_node_s0", 32'(ifb.node_s0), mb.s0);
        check_eq("b_node_s1", 32'(ifb.node_s1), mb.s1);
        check_eq("b_match",   32'(ifb.match),   32'(mb.s0 == mb.s1));
        check_eq("b_s0_steps", 32'(b_s0_steps), mb.st0);
        check_eq("b_s1_steps", 32'(b_s1_steps), mb.st1);
        check_eq("b_found",   32'(b_found),     32'(mb.found));
        check_eq("b_cstep",   32'(b_cstep),     mb.cstep);
    endtask

    task automatic drive(input bit r, input bit rn, input logic [3:0] ini, input bit a, input bit b,
                         input logic [3:0] n0, input logic [3:0] n1, input logic n0b, input logic n1b);
        rst          = r;
        reset_nos    = rn;
        init_a       = ini;
        init_b       = ini[0];
        ifa.start_s0 = a;
        ifa.start_s1 = b;
        ifa.next_s0  = n0;
        ifa.next_s1  = n1;
        ifb.start_s0 = a;
        ifb.start_s1 = b;
        ifb.next_s0  = n0b;
        ifb.next_s1  = n1b;
        @(posedge clk);
        ma = mdl_step(ma, r, rn, 32'(ini), a, b, 32'(n0), 32'(n1), 2, 7);
        mb = mdl_step(mb, r, rn, 32'(ini[0]), a, b, 32'(n0b), 32'(n1b), 3, 255);
        #1;
        compare_all();
    endtask

    function automatic logic [3:0] loop3(input int unsigned s);
        return (s == 3) ? 4'd1 : 4'(s + 1);
    endfunction

    initial begin
        logic [3:0] iv, n0, n1;
        logic       n0b, n1b;
        bit         r, rn, a, b;

        // Reset defaults and first-strobe skip
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_s0", 32'(ifa.s0), 0);
        check_eq("rst_s1_steps", 32'(a_s1_steps), 0);
        check_eq("rst_found", 32'(a_found), 0);
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0);
        check_eq("skip_s0", 32'(ifa.s0), 0);
        check_eq("skip_s0_steps", 32'(a_s0_steps), 0);
        drive(0, 0, 0, 1, 0, 1, 0, 1, 0);
        check_eq("second_s0", 32'(ifa.s0), 1);
        check_eq("second_s0_steps", 32'(a_s0_steps), 1);

        // Restart then divider on alternating candidates
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            iv = 4'(i % 2);
            drive(0, 0, 0, 1, 0, iv, 0, iv[0], 0);
            if (i == 0) check_eq("div_s0_after1", 32'(ifa.s0), 0);
        end
        check_eq("div_s0", 32'(ifa.s0), 0);
        check_eq("div_s0_steps", 32'(a_s0_steps), 2);

        // Fast copy tracking and 3-bit counter saturation
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            iv = 4'(i);
            drive(0, 0, 0, 0, 1, 0, iv, 0, iv[0]);
            check_eq("sat_s1", 32'(ifa.s1), 32'(iv));
            check_eq("sat_s1_steps", 32'(a_s1_steps), (i < 7) ? 32'(i + 1) : 32'd7);
        end

        // 3-state loop 1->2->3->1 on both copies
        drive(0, 1, 1, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 1, loop3(ma.s0), loop3(ma.s1), ~mb.s0[0], ~mb.s1[0]);
            if (i == 0) check_eq("loop_found_early", 32'(a_found), 0);
            if (i == 1) check_eq("loop_found", 32'(a_found), 1);
            if (i >= 1) check_eq("loop_cstep", 32'(a_cstep), 1);
        end

        // Restart wins over same-cycle strobes
        drive(0, 1, 5, 1, 1, 7, 7, 0, 0);
        check_eq("sim_s0", 32'(ifa.s0), 5);
        check_eq("sim_s1", 32'(ifa.s1), 5);
        check_eq("sim_s1_steps", 32'(a_s1_steps), 0);
        drive(0, 0, 0, 1, 0, 9, 0, 0, 0);
        check_eq("sim_phase0_s0", 32'(ifa.s0), 9);

        // rst in a detect cycle, then sticky and clear on restart
        drive(0, 1, 3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_beats_detect", 32'(a_found), 0);
        drive(0, 1, 3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("sticky_found", 32'(a_found), 1);
        check_eq("sticky_cstep", 32'(a_cstep), 1);
        drive(0, 0, 0, 0, 1, 0, 3, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("sticky_cstep_hold", 32'(a_cstep), 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("clear_found", 32'(a_found), 0);
        check_eq("clear_cstep", 32'(a_cstep), 0);

        // Randomized runs with node update driven by a random state map
        for (int k = 0; k < 16; k++) tbl_a[k] = $urandom_range(0, 15);
        for (int k = 0; k < 2; k++) tbl_b[k] = $urandom_range(0, 1);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 39) == 0);
            a  = $urandom_range(0, 1) == 1;
            b  = $urandom_range(0, 1) == 1;
            if (rn) begin
                for (int k = 0; k < 16; k++) tbl_a[k] = $urandom_range(0, 15);
                for (int k = 0; k < 2; k++) tbl_b[k] = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 9) < 8) begin
                n0  = 4'(tbl_a[ma.s0]);
                n1  = 4'(tbl_a[ma.s1]);
                n0b = tbl_b[mb.s0][0];
                n1b = tbl_b[mb.s1][0];
            end else begin
                n0  = 4'($urandom_range(0, 15));
                n1  = 4'($urandom_range(0, 15));
                n0b = 1'($urandom_range(0, 1));
                n1b = 1'($urandom_range(0, 1));
            end
            drive(r, rn, 4'($urandom_range(0, 15)), a, b, n0, n1, n0b, n1b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
